// File: rtl/exu_branch_jump_unit.sv
// exu_branch_jump_unit: execute-stage resolver for JAL, JALR and the six RV32 branches.
// Optional macro MISALIGN_TRAP_EN: taken targets with bit 1 set trap instead of redirecting.
module exu_branch_jump_unit #(
    parameter int XLEN            = 32,
    parameter int PC_LAG          = 8,
    parameter int PIPE_DEPTH      = 2,
    parameter int REDIRECT_CYCLES = 2,
    parameter int FLUSH_W         = 2
) (
    input  logic               hclk,
    input  logic               hrst,
    input  logic               start,
    input  logic               kill,
    input  logic [2:0]         op,
    input  logic [4:0]         dec_rd,
    input  logic [4:0]         dec_rs1,
    input  logic [4:0]         dec_rs2,
    input  logic [11:0]        dec_imm_i,
    input  logic [20:0]        dec_imm_j,
    input  logic [12:0]        dec_imm_b,
    input  logic [XLEN-1:0]    pc,
    output logic               busy,
    output logic               done,
    output logic [4:0]         reg_raddr_1,
    output logic               reg_ren_1,
    input  logic [XLEN-1:0]    reg_rdata_1,
    output logic [4:0]         reg_raddr_2,
    output logic               reg_ren_2,
    input  logic [XLEN-1:0]    reg_rdata_2,
    output logic [4:0]         reg_waddr,
    output logic               reg_wen,
    output logic [XLEN-1:0]    reg_wdata,
    output logic               pc_write,
    output logic [XLEN-1:0]    pc_wdata,
    output logic [FLUSH_W-1:0] flush,
`ifdef MISALIGN_TRAP_EN
    output logic               misalign,
    output logic [XLEN-1:0]    misalign_addr,
`endif
    output logic               taken
);

    localparam logic [2:0] OP_JAL  = 3'd0;
    localparam logic [2:0] OP_JALR = 3'd1;
    localparam logic [2:0] OP_BEQ  = 3'd2;
    localparam logic [2:0] OP_BNE  = 3'd3;
    localparam logic [2:0] OP_BLT  = 3'd4;
    localparam logic [2:0] OP_BGE  = 3'd5;
    localparam logic [2:0] OP_BLTU = 3'd6;
    localparam int CNT_W = (REDIRECT_CYCLES > 1) ? $clog2(REDIRECT_CYCLES) : 1;

    typedef enum logic [2:0] {S_IDLE, S_READ, S_EVAL, S_WB, S_REDIR, S_DONE} state_t;

    state_t              r_state, w_next;
    logic [CNT_W-1:0]    r_cnt;
    logic [2:0]          r_op;
    logic [4:0]          r_rd, r_rs1, r_rs2;
    logic [11:0]         r_imm_i;
    logic [20:0]         r_imm_j;
    logic [12:0]         r_imm_b;
    logic [XLEN-1:0]     r_pc_real, r_target;
    logic                r_taken, r_redir;
    logic [FLUSH_W-1:0]  r_flush;
`ifdef MISALIGN_TRAP_EN
    logic                r_misalign;
`endif

    logic [XLEN-1:0]     w_sx_i, w_sx_j, w_sx_b, w_target, w_d, w_k;
    logic                w_taken, w_inrange;

    assign w_sx_i = {{(XLEN-12){r_imm_i[11]}}, r_imm_i};
    assign w_sx_j = {{(XLEN-21){r_imm_j[20]}}, r_imm_j};
    assign w_sx_b = {{(XLEN-13){r_imm_b[12]}}, r_imm_b};

    // EVAL datapath: direction, target and distance from the executing PC
    always_comb begin
        w_taken = 1'b1;
        case (r_op)
            OP_BEQ:  w_taken = (reg_rdata_1 == reg_rdata_2);
            OP_BNE:  w_taken = (reg_rdata_1 != reg_rdata_2);
            OP_BLT:  w_taken = ($signed(reg_rdata_1) <  $signed(reg_rdata_2));
            OP_BGE:  w_taken = ($signed(reg_rdata_1) >= $signed(reg_rdata_2));
            OP_BLTU: w_taken = (reg_rdata_1 <  reg_rdata_2);
            3'd7:    w_taken = (reg_rdata_1 >= reg_rdata_2);
            default: w_taken = 1'b1;
        endcase
        case (r_op)
            OP_JAL:  w_target = r_pc_real + w_sx_j;
            OP_JALR: w_target = (reg_rdata_1 + w_sx_i) & {{(XLEN-1){1'b1}}, 1'b0};
            default: w_target = w_taken ? (r_pc_real + w_sx_b) : (r_pc_real + XLEN'(4));
        endcase
        w_d       = w_target - r_pc_real;
        w_k       = w_d >> 2;
        // Targets landing on an already-fetched younger slot need no redirect
        w_inrange = (w_d[1:0] == 2'b00) && (w_k >= XLEN'(1)) && (w_k <= XLEN'(PIPE_DEPTH));
    end

    always_ff @(posedge hclk) begin
        if (r_state == S_IDLE && start) begin
            r_op      <= op;
            r_rd      <= dec_rd;
            r_rs1     <= dec_rs1;
            r_rs2     <= dec_rs2;
            r_imm_i   <= dec_imm_i;
            r_imm_j   <= dec_imm_j;
            r_imm_b   <= dec_imm_b;
            r_pc_real <= pc - XLEN'(PC_LAG);
        end
        if (r_state == S_EVAL) begin
            r_taken  <= w_taken;
            r_target <= w_target;
            r_redir  <= !w_inrange;
            r_flush  <= w_inrange ? FLUSH_W'(w_k - XLEN'(1)) : FLUSH_W'(PIPE_DEPTH);
`ifdef MISALIGN_TRAP_EN
            r_misalign <= w_taken && w_target[1];
`endif
        end
    end

    always_ff @(posedge hclk or posedge hrst) begin
        if (hrst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= (r_state == S_REDIR && w_next == S_REDIR) ? r_cnt + 1'b1 : '0;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_READ;
            S_READ:  w_next = S_EVAL;
`ifdef MISALIGN_TRAP_EN
            S_EVAL:  w_next = (w_taken && w_target[1]) ? S_DONE : S_WB;
`else
            S_EVAL:  w_next = S_WB;
`endif
            S_WB:    w_next = S_REDIR;
            S_REDIR: if (r_cnt == CNT_W'(REDIRECT_CYCLES - 1)) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
        if (kill && r_state != S_IDLE) w_next = S_IDLE;
    end

    always_comb begin
        busy        = (r_state != S_IDLE);
        done        = (r_state == S_DONE);
        reg_ren_1   = (r_state == S_READ) && (r_op != OP_JAL);
        reg_raddr_1 = reg_ren_1 ? r_rs1 : 5'd0;
        reg_ren_2   = (r_state == S_READ) && (r_op >= OP_BEQ);
        reg_raddr_2 = reg_ren_2 ? r_rs2 : 5'd0;
        reg_wen     = (r_state == S_WB) && (r_op <= OP_JALR) && (r_rd != 5'd0);
        reg_waddr   = reg_wen ? r_rd : 5'd0;
        reg_wdata   = reg_wen ? (r_pc_real + XLEN'(4)) : '0;
        pc_write    = (r_state == S_REDIR) && r_redir;
        pc_wdata    = pc_write ? r_target : '0;
        flush       = (r_state == S_REDIR) ? r_flush : '0;
        taken       = (r_state == S_WB || r_state == S_REDIR || r_state == S_DONE) && r_taken;
`ifdef MISALIGN_TRAP_EN
        misalign      = (r_state == S_DONE) && r_misalign;
        misalign_addr = misalign ? r_target : '0;
        if (misalign) flush = FLUSH_W'(PIPE_DEPTH);
`endif
    end

endmodule

// File: tb/tb_exu_branch_jump_unit.sv
// Bench for exu_branch_jump_unit: vector table with scoreboard plus kill/reset/restart sequences.
module tb_exu_branch_jump_unit;

    logic        hclk = 1'b0;
    logic        hrst, start, kill;
    logic [2:0]  op;
    logic [4:0]  dec_rd, dec_rs1, dec_rs2;
    logic [11:0] dec_imm_i;
    logic [20:0] dec_imm_j;
    logic [12:0] dec_imm_b;
    logic [31:0] pc, reg_rdata_1, reg_rdata_2;
    logic        busy, done, reg_ren_1, reg_ren_2, reg_wen, pc_write, taken;
    logic [4:0]  reg_raddr_1, reg_raddr_2, reg_waddr;
    logic [31:0] reg_wdata, pc_wdata;
    logic [1:0]  flush;
`ifdef MISALIGN_TRAP_EN
    logic        misalign;
    logic [31:0] misalign_addr;
`endif

    exu_branch_jump_unit dut (
        .hclk(hclk), .hrst(hrst), .start(start), .kill(kill), .op(op),
        .dec_rd(dec_rd), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
        .dec_imm_i(dec_imm_i), .dec_imm_j(dec_imm_j), .dec_imm_b(dec_imm_b), .pc(pc),
        .busy(busy), .done(done),
        .reg_raddr_1(reg_raddr_1), .reg_ren_1(reg_ren_1), .reg_rdata_1(reg_rdata_1),
        .reg_raddr_2(reg_raddr_2), .reg_ren_2(reg_ren_2), .reg_rdata_2(reg_rdata_2),
        .reg_waddr(reg_waddr), .reg_wen(reg_wen), .reg_wdata(reg_wdata),
        .pc_write(pc_write), .pc_wdata(pc_wdata), .flush(flush),
`ifdef MISALIGN_TRAP_EN
        .misalign(misalign), .misalign_addr(misalign_addr),
`endif
        .taken(taken)
    );

    always #5 hclk = ~hclk;

    typedef struct {
        logic [2:0]  op;
        logic [4:0]  rd, rs1, rs2;
        logic [11:0] imm_i;
        logic [20:0] imm_j;
        logic [12:0] imm_b;
        logic [31:0] pc, rd1, rd2;
        logic        exp_taken, exp_wen;
        logic [31:0] exp_wdata;
        logic        exp_pcw;
        logic [31:0] exp_tgt;
        logic [1:0]  exp_flush;
        logic        mis;
    } vec_t;

    vec_t vecs[12];
    vec_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [2:0] o, input logic [4:0] rd, input logic [4:0] rs1,
                                input logic [4:0] rs2, input logic [11:0] ii, input logic [20:0] ij,
                                input logic [12:0] ib, input logic [31:0] p, input logic [31:0] r1,
                                input logic [31:0] r2, input logic tk, input logic wen,
                                input logic [31:0] wd, input logic pcw, input logic [31:0] tgt,
                                input logic [1:0] fl, input logic mis);
        vec_t v;
        v.op = o; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2;
        v.imm_i = ii; v.imm_j = ij; v.imm_b = ib; v.pc = p; v.rd1 = r1; v.rd2 = r2;
        v.exp_taken = tk; v.exp_wen = wen; v.exp_wdata = wd;
        v.exp_pcw = pcw; v.exp_tgt = tgt; v.exp_flush = fl; v.mis = mis;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        op = v.op; dec_rd = v.rd; dec_rs1 = v.rs1; dec_rs2 = v.rs2;
        dec_imm_i = v.imm_i; dec_imm_j = v.imm_j; dec_imm_b = v.imm_b;
        pc = v.pc; reg_rdata_1 = v.rd1; reg_rdata_2 = v.rd2;
    endtask

    // Full operation; glitch re-pulses start with a different op during READ
    task automatic run_vec(input int i, input bit glitch);
        vec_t v;
        vec_t e;
        v = vecs[i];
        @(negedge hclk);
        drive(v); start = 1'b1; sb.push_back(v);
        @(negedge hclk);
        if (glitch) begin op = 3'd6; start = 1'b1; end
        else start = 1'b0;
        check($sformatf("v%0d busy_read", i), 32'(busy), 32'd1);
        check($sformatf("v%0d ren1", i), 32'(reg_ren_1), 32'(v.op != 3'd0));
        if (v.op != 3'd0) check($sformatf("v%0d raddr1", i), 32'(reg_raddr_1), 32'(v.rs1));
        check($sformatf("v%0d ren2", i), 32'(reg_ren_2), 32'(v.op >= 3'd2));
        if (v.op >= 3'd2) check($sformatf("v%0d raddr2", i), 32'(reg_raddr_2), 32'(v.rs2));
        @(negedge hclk);
        start = 1'b0; op = v.op;
        @(negedge hclk);
        if (sb.size() == 0) begin
            n_checks++; n_errors++;
            $display("FAIL v%0d scoreboard: got empty expected entry", i);
            e = v;
        end else e = sb.pop_front();
        check($sformatf("v%0d wen", i), 32'(reg_wen), 32'(e.exp_wen));
        if (e.exp_wen) begin
            check($sformatf("v%0d waddr", i), 32'(reg_waddr), 32'(e.rd));
            check($sformatf("v%0d wdata", i), reg_wdata, e.exp_wdata);
        end
        check($sformatf("v%0d taken_wb", i), 32'(taken), 32'(e.exp_taken));
        check($sformatf("v%0d done_wb", i), 32'(done), 32'd0);
        for (int c = 0; c < 2; c++) begin
            @(negedge hclk);
            check($sformatf("v%0d pc_write%0d", i, c), 32'(pc_write), 32'(e.exp_pcw));
            if (e.exp_pcw) check($sformatf("v%0d pc_wdata%0d", i, c), pc_wdata, e.exp_tgt);
            check($sformatf("v%0d flush%0d", i, c), 32'(flush), 32'(e.exp_flush));
            check($sformatf("v%0d taken_rd%0d", i, c), 32'(taken), 32'(e.exp_taken));
        end
        @(negedge hclk);
        check($sformatf("v%0d done", i), 32'(done), 32'd1);
        check($sformatf("v%0d pc_write_done", i), 32'(pc_write), 32'd0);
        @(negedge hclk);
        check($sformatf("v%0d done_after", i), 32'(done), 32'd0);
        check($sformatf("v%0d busy_after", i), 32'(busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int saw_done;
        vecs[0]  = mk(3'd0, 5'd1, 5'd0, 5'd0, 12'h0, 21'h40, 13'h0, 32'h108, 32'h0, 32'h0,
                      1'b1, 1'b1, 32'h104, 1'b1, 32'h140, 2'd2, 1'b0);
        vecs[1]  = mk(3'd0, 5'd0, 5'd0, 5'd0, 12'h0, 21'h8, 13'h0, 32'h108, 32'h0, 32'h0,
                      1'b1, 1'b0, 32'h0, 1'b0, 32'h108, 2'd1, 1'b0);
        vecs[2]  = mk(3'd0, 5'd0, 5'd0, 5'd0, 12'h0, 21'h4, 13'h0, 32'h108, 32'h0, 32'h0,
                      1'b1, 1'b0, 32'h0, 1'b0, 32'h104, 2'd0, 1'b0);
        vecs[3]  = mk(3'd1, 5'd1, 5'd5, 5'd0, 12'hFFF, 21'h0, 13'h0, 32'h108, 32'h2003, 32'h0,
                      1'b1, 1'b1, 32'h104, 1'b1, 32'h2002, 2'd2, 1'b1);
        vecs[4]  = mk(3'd4, 5'd7, 5'd3, 5'd4, 12'h0, 21'h0, 13'h1FF0, 32'h108, 32'hFFFFFFFF, 32'h1,
                      1'b1, 1'b0, 32'h0, 1'b1, 32'hF0, 2'd2, 1'b0);
        vecs[5]  = mk(3'd6, 5'd7, 5'd3, 5'd4, 12'h0, 21'h0, 13'h1FF0, 32'h108, 32'hFFFFFFFF, 32'h1,
                      1'b0, 1'b0, 32'h0, 1'b0, 32'h104, 2'd0, 1'b0);
        vecs[6]  = mk(3'd2, 5'd3, 5'd8, 5'd9, 12'h0, 21'h0, 13'h8, 32'h108, 32'h55, 32'h55,
                      1'b1, 1'b0, 32'h0, 1'b0, 32'h108, 2'd1, 1'b0);
        vecs[7]  = mk(3'd3, 5'd3, 5'd8, 5'd9, 12'h0, 21'h0, 13'h8, 32'h108, 32'h55, 32'h55,
                      1'b0, 1'b0, 32'h0, 1'b0, 32'h104, 2'd0, 1'b0);
        vecs[8]  = mk(3'd5, 5'd0, 5'd10, 5'd11, 12'h0, 21'h0, 13'hC, 32'h108, 32'hFFFFFFFB, 32'hFFFFFFFB,
                      1'b1, 1'b0, 32'h0, 1'b1, 32'h10C, 2'd2, 1'b0);
        vecs[9]  = mk(3'd7, 5'd0, 5'd12, 5'd13, 12'h0, 21'h0, 13'h40, 32'h108, 32'h1, 32'hFFFFFFFF,
                      1'b0, 1'b0, 32'h0, 1'b0, 32'h104, 2'd0, 1'b0);
        vecs[10] = mk(3'd1, 5'd2, 5'd6, 5'd0, 12'h008, 21'h0, 13'h0, 32'h108, 32'h100, 32'h0,
                      1'b1, 1'b1, 32'h104, 1'b0, 32'h108, 2'd1, 1'b0);
        vecs[11] = mk(3'd0, 5'd31, 5'd0, 5'd0, 12'h0, 21'h1FFFFC, 13'h0, 32'h108, 32'h0, 32'h0,
                      1'b1, 1'b1, 32'h104, 1'b1, 32'hFC, 2'd2, 1'b0);

        hrst = 1'b1; start = 1'b0; kill = 1'b0;
        drive(vecs[0]);
        repeat (2) @(negedge hclk);
        check("rst busy", 32'(busy), 32'd0);
        check("rst done", 32'(done), 32'd0);
        check("rst ren1", 32'(reg_ren_1), 32'd0);
        check("rst wen", 32'(reg_wen), 32'd0);
        check("rst pc_write", 32'(pc_write), 32'd0);
        check("rst flush", 32'(flush), 32'd0);
        check("rst taken", 32'(taken), 32'd0);
        hrst = 1'b0;

        for (int i = 0; i < 12; i++) begin
`ifdef MISALIGN_TRAP_EN
            if (!vecs[i].mis) run_vec(i, 1'b0);
`else
            run_vec(i, 1'b0);
`endif
        end

`ifdef MISALIGN_TRAP_EN
        begin
            vec_t e;
            @(negedge hclk);
            drive(vecs[3]); start = 1'b1; sb.push_back(vecs[3]);
            @(negedge hclk); start = 1'b0;
            @(negedge hclk);
            check("mis wen_eval", 32'(reg_wen), 32'd0);
            @(negedge hclk);
            e = sb.pop_front();
            check("mis done", 32'(done), 32'd1);
            check("mis flag", 32'(misalign), 32'd1);
            check("mis addr", misalign_addr, e.exp_tgt);
            check("mis flush", 32'(flush), 32'd2);
            check("mis wen", 32'(reg_wen), 32'd0);
            check("mis pc_write", 32'(pc_write), 32'd0);
            @(negedge hclk);
            check("mis busy_after", 32'(busy), 32'd0);
            check("mis flag_after", 32'(misalign), 32'd0);
        end
`endif

        // Restart attempt during READ must not disturb the BLT in flight
        run_vec(4, 1'b1);

        // Kill in the first REDIRECT cycle
        @(negedge hclk);
        drive(vecs[0]); start = 1'b1;
        @(negedge hclk); start = 1'b0;
        @(negedge hclk);
        @(negedge hclk);
        @(negedge hclk);
        check("kill pc_write_before", 32'(pc_write), 32'd1);
        kill = 1'b1;
        @(negedge hclk);
        kill = 1'b0;
        check("kill pc_write", 32'(pc_write), 32'd0);
        check("kill flush", 32'(flush), 32'd0);
        check("kill busy", 32'(busy), 32'd0);
        saw_done = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge hclk);
            if (done) saw_done = 1;
        end
        check("kill no_done", 32'(saw_done), 32'd0);

        // Asynchronous reset while in EVAL
        @(negedge hclk);
        drive(vecs[4]); start = 1'b1;
        @(negedge hclk); start = 1'b0;
        @(negedge hclk);
        check("rst_mid busy_before", 32'(busy), 32'd1);
        hrst = 1'b1;
        #1;
        check("rst_mid busy", 32'(busy), 32'd0);
        check("rst_mid done", 32'(done), 32'd0);
        check("rst_mid ren", 32'(reg_ren_1), 32'd0);
        check("rst_mid pc_write", 32'(pc_write), 32'd0);
        check("rst_mid flush", 32'(flush), 32'd0);
        @(negedge hclk);
        hrst = 1'b0;
        saw_done = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge hclk);
            if (done || busy) saw_done = 1;
        end
        check("rst_mid quiet", 32'(saw_done), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
